fork_module: RTL and testbench

// - KPN fork node, the 1-to-2 counterpart of the 2-to-1 arithmetic nodes (e.g. subtractor_module).
// - Consumes one 16-bit token stream and delivers every token, in order, to two independent consumer streams.
// - Buffers each branch separately, so one stalled consumer does not block the other until its buffer fills.
// - Sits between a producer and two downstream KPN process nodes.

---
 rtl/fork_module_pkg.sv | 24 ++
 rtl/fork_module_if.sv | 33 +++
 rtl/fork_module_channel_fifo.sv | 79 +++++++
 rtl/fork_module.sv | 70 +++++++
 tb/tb_fork_module.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fork_module_pkg.sv
// Shared definitions for the KPN fork node.
// Holds the channel width and buffer geometry used by every KPN node, plus
// a small helper that names the four push/pop combinations a per-branch
// FIFO can see on one clock edge.
package fork_module_pkg;

    localparam int KPN_DATA_WIDTH    = 16;
    localparam int FORK_DEPTH        = 4;
    localparam int FORK_ADDR_WIDTH   = 2;
    localparam int TOKEN_COUNT_WIDTH = 16;

    // Encoding is {push, pop} so the helper below is a plain cast.
    typedef enum logic [1:0] {
        FIFO_IDLE     = 2'b00,
        FIFO_POP      = 2'b01,
        FIFO_PUSH     = 2'b10,
        FIFO_PUSH_POP = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/fork_module_if.sv
// Valid/ready bundle of the fork node: one producer-side channel (entry_1)
// and two consumer-side channels (output_1, output_2).
//   master : the environment (producer + both consumers)
//   slave  : the fork node itself
interface fork_module_if
    import fork_module_pkg::*;
#(
    parameter int DATA_WIDTH = KPN_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] entry_1;
    logic                  entry_1_valid;
    logic                  entry_1_ready;

    logic [DATA_WIDTH-1:0] output_1;
    logic                  output_1_valid;
    logic                  output_1_ready;

    logic [DATA_WIDTH-1:0] output_2;
    logic                  output_2_valid;
    logic                  output_2_ready;

    modport master (
        output entry_1, entry_1_valid, output_1_ready, output_2_ready,
        input  entry_1_ready, output_1, output_1_valid, output_2, output_2_valid
    );

    modport slave (
        input  entry_1, entry_1_valid, output_1_ready, output_2_ready,
        output entry_1_ready, output_1, output_1_valid, output_2, output_2_valid
    );

endinterface

// File: rtl/fork_module_channel_fifo.sv
// fork_channel_fifo: one branch buffer of the fork node.
// DEPTH x DATA_WIDTH first-word-fall-through FIFO; the head token is visible
// on head_data whenever head_valid is high, and reads as zero when empty.
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   push           write push_data this edge (ignored when full)
//   push_data      token to store
//   pop_ready      consumer takes the head token (ignored when empty)
//   head_data      current head token, 0 when empty
//   head_valid     FIFO non-empty
//   full           FIFO holds DEPTH tokens
module fork_channel_fifo
    import fork_module_pkg::*;
#(
    parameter int DATA_WIDTH = KPN_DATA_WIDTH,
    parameter int DEPTH      = FORK_DEPTH,
    parameter int ADDR_WIDTH = FORK_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop_ready,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_valid,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  write_en;
    logic                  pop;

    assign head_valid = (count != '0);
    assign full       = (count == (ADDR_WIDTH + 1)'(DEPTH));
    assign write_en   = push && !full;
    assign pop        = head_valid && pop_ready;

    // Head is masked to zero when empty so stale storage never leaks out.
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    // Storage needs no reset: an entry is only observable once count
    // covers it, and a reset clears count.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is exactly 2**ADDR_WIDTH.
    // A simultaneous push and pop moves both pointers and leaves count alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            case (fifo_op(write_en, pop))
                FIFO_PUSH: begin
                    wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                    count  <= count + (ADDR_WIDTH + 1)'(1);
                end
                FIFO_POP: begin
                    rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                    count  <= count - (ADDR_WIDTH + 1)'(1);
                end
                FIFO_PUSH_POP: begin
                    wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                    rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fork_module.sv
// fork_module: KPN fork node. Every accepted entry_1 token is copied, in
// order, into two independent branch FIFOs so one stalled consumer only
// blocks the producer once its own buffer is full.
// Ports:
//   clk, reset_n    clock and asynchronous active-low reset
//   bus (slave)     entry_1 / output_1 / output_2 valid-ready channels
//   tokens_forked   count of accepted input tokens, wraps modulo 2**16
module fork_module
    import fork_module_pkg::*;
#(
    parameter int DATA_WIDTH = KPN_DATA_WIDTH,
    parameter int DEPTH      = FORK_DEPTH,
    parameter int ADDR_WIDTH = FORK_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    fork_module_if.slave                 bus,
    output logic [TOKEN_COUNT_WIDTH-1:0] tokens_forked
);

    logic full_1;
    logic full_2;
    logic push;

    // Ready depends only on the registered FIFO counts, never on the
    // consumers' ready inputs. reset_n gates it so the producer sees
    // not-ready for the whole time reset is held.
    assign bus.entry_1_ready = reset_n && !full_1 && !full_2;
    assign push              = bus.entry_1_valid && bus.entry_1_ready;

    fork_channel_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_branch_1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_data  (bus.entry_1),
        .pop_ready  (bus.output_1_ready),
        .head_data  (bus.output_1),
        .head_valid (bus.output_1_valid),
        .full       (full_1)
    );

    fork_channel_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_branch_2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_data  (bus.entry_1),
        .pop_ready  (bus.output_2_ready),
        .head_data  (bus.output_2),
        .head_valid (bus.output_2_valid),
        .full       (full_2)
    );

    // Counts accepted tokens; relies on natural 16-bit wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tokens_forked <= '0;
        end else if (push) begin
            tokens_forked <= tokens_forked + TOKEN_COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fork_module.sv
// Testbench for fork_module: directed scenarios plus a randomized phase.
// The driver records each accepted token into two expected queues (one per
// branch); an independent monitor compares the DUT's branch heads, valids,
// entry_1_ready and tokens_forked against those queues every cycle.
module tb_fork_module;

    localparam int DEPTH = 4;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] tokens_forked;

    fork_module_if bus ();

    fork_module dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .tokens_forked (tokens_forked)
    );

    always #5 clk = ~clk;

    logic [15:0] exp_q1 [$];
    logic [15:0] exp_q2 [$];
    logic [15:0] model_tokens   = '0;
    int          checks         = 0;
    int          errors         = 0;
    bit          monitor_on     = 1'b0;
    bit          pending_accept = 1'b0;
    logic [15:0] pending_data   = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // A token accepted on the previous edge is now inside both FIFOs.
    task automatic commitPending();
        if (pending_accept) begin
            exp_q1.push_back(pending_data);
            exp_q2.push_back(pending_data);
            model_tokens = model_tokens + 16'd1;
        end
        pending_accept = 1'b0;
    endtask

    // One clock cycle of stimulus: inputs change just after the rising edge
    // and the acceptance decision is read at the falling edge.
    task automatic applyStimulus(input logic valid, input logic [15:0] data,
                                 input logic r1, input logic r2);
        @(posedge clk);
        #1;
        commitPending();
        bus.entry_1_valid  = valid;
        bus.entry_1        = data;
        bus.output_1_ready = r1;
        bus.output_2_ready = r2;
        @(negedge clk);
        pending_accept = valid && bus.entry_1_ready;
        pending_data   = data;
    endtask

    // Asserts reset between clock edges, checks that everything drops
    // immediately, then releases it just after a falling edge.
    task automatic resetDut();
        @(posedge clk);
        #1;
        monitor_on         = 1'b0;
        pending_accept     = 1'b0;
        bus.entry_1_valid  = 1'b0;
        bus.entry_1        = '0;
        bus.output_1_ready = 1'b0;
        bus.output_2_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_valid_1", 32'(bus.output_1_valid), 32'd0);
        checkOutput("rst_valid_2", 32'(bus.output_2_valid), 32'd0);
        checkOutput("rst_output_1", 32'(bus.output_1), 32'd0);
        checkOutput("rst_output_2", 32'(bus.output_2), 32'd0);
        checkOutput("rst_entry_ready", 32'(bus.entry_1_ready), 32'd0);
        checkOutput("rst_tokens", 32'(tokens_forked), 32'd0);
        exp_q1.delete();
        exp_q2.delete();
        model_tokens = '0;
        @(negedge clk);
        #1;
        reset_n    = 1'b1;
        monitor_on = 1'b1;
        #1;
        checkOutput("ready_after_reset", 32'(bus.entry_1_ready), 32'd1);
    endtask

    // Monitor: compares DUT state against the expected queues every cycle
    // and retires a queue head whenever that branch's consumer takes it.
    always begin
        @(negedge clk);
        #2;
        if (monitor_on) begin
            checkOutput("valid_1", 32'(bus.output_1_valid), 32'(exp_q1.size() != 0));
            checkOutput("valid_2", 32'(bus.output_2_valid), 32'(exp_q2.size() != 0));
            checkOutput("entry_ready", 32'(bus.entry_1_ready),
                        32'((exp_q1.size() < DEPTH) && (exp_q2.size() < DEPTH)));
            checkOutput("tokens_forked", 32'(tokens_forked), 32'(model_tokens));
            if (exp_q1.size() == 0) begin
                checkOutput("output_1_empty", 32'(bus.output_1), 32'd0);
            end else begin
                checkOutput("output_1", 32'(bus.output_1), 32'(exp_q1[0]));
                if (bus.output_1_ready) begin
                    void'(exp_q1.pop_front());
                end
            end
            if (exp_q2.size() == 0) begin
                checkOutput("output_2_empty", 32'(bus.output_2), 32'd0);
            end else begin
                checkOutput("output_2", 32'(bus.output_2), 32'(exp_q2[0]));
                if (bus.output_2_ready) begin
                    void'(exp_q2.pop_front());
                end
            end
        end
    end

    // Absolute time limit so the run always ends.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.entry_1_valid  = 1'b0;
        bus.entry_1        = '0;
        bus.output_1_ready = 1'b0;
        bus.output_2_ready = 1'b0;

        // Reset then idle.
        resetDut();
        repeat (3) applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);

        // Three tokens straight through both branches.
        applyStimulus(1'b1, 16'd20, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'd45, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'd90, 1'b1, 1'b1);
        repeat (3) applyStimulus(1'b0, 16'd0, 1'b1, 1'b1);
        #2;
        checkOutput("tokens_after_3", 32'(tokens_forked), 32'd3);

        // Back-pressure: both consumers stalled, only DEPTH tokens fit.
        resetDut();
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b1, 16'(k), 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
        #2;
        checkOutput("bp_ready_low", 32'(bus.entry_1_ready), 32'd0);
        checkOutput("bp_head_1", 32'(bus.output_1), 32'd1);
        checkOutput("bp_head_2", 32'(bus.output_2), 32'd1);
        checkOutput("bp_tokens", 32'(tokens_forked), 32'd4);
        repeat (4) applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
        #2;
        checkOutput("bp_branch1_drained", 32'(bus.output_1_valid), 32'd0);
        checkOutput("bp_still_blocked", 32'(bus.entry_1_ready), 32'd0);
        checkOutput("bp_branch2_head", 32'(bus.output_2), 32'd1);
        repeat (4) applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
        #2;
        checkOutput("bp_ready_back", 32'(bus.entry_1_ready), 32'd1);

        // Simultaneous push and pop on branch 1 holding two tokens.
        resetDut();
        applyStimulus(1'b1, 16'd10, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'd11, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'd7, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
        #2;
        checkOutput("pp_head_1", 32'(bus.output_1), 32'd11);
        repeat (3) applyStimulus(1'b0, 16'd0, 1'b1, 1'b1);
        #2;
        checkOutput("pp_drained", 32'(bus.output_1_valid), 32'd0);

        // Mid-operation reset with three tokens buffered.
        applyStimulus(1'b1, 16'hA1, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hA2, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hA3, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
        resetDut();
        repeat (3) applyStimulus(1'b0, 16'd0, 1'b1, 1'b1);

        // Counter and pointer wrap: 65536 tokens with free-flowing outputs.
        resetDut();
        for (int i = 0; i < 65536; i++) begin
            applyStimulus(1'b1, 16'(i), 1'b1, 1'b1);
        end
        repeat (2) applyStimulus(1'b0, 16'd0, 1'b1, 1'b1);
        #2;
        checkOutput("wrap_tokens", 32'(tokens_forked), 32'd0);

        // Randomized traffic with independent, sometimes stalling consumers.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom),
                          1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 2) == 0));
        end
        repeat (2 * DEPTH + 2) applyStimulus(1'b0, 16'd0, 1'b1, 1'b1);
        #2;
        checkOutput("final_empty_1", 32'(bus.output_1_valid), 32'd0);
        checkOutput("final_empty_2", 32'(bus.output_2_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
